// File: rtl/calc_share_arbiter.sv
// calc_share_arbiter: round-robin sharing of one calculator between two requesters,
// with a calculator clear whenever the chained accumulator would change hands.
module calc_share_arbiter #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        clr0,
    input  logic        clr1,
    input  logic [7:0]  num1_0,
    input  logic [7:0]  num1_1,
    input  logic [7:0]  num2_0,
    input  logic [7:0]  num2_1,
    input  logic [2:0]  func_0,
    input  logic [2:0]  func_1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [31:0] result,
    output logic        calc_rst,
    output logic        calc_button,
    output logic [7:0]  calc_num1,
    output logic [7:0]  calc_num2,
    output logic [2:0]  calc_func,
    input  logic [31:0] cal_result
);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    typedef enum logic [2:0] {S_IDLE, S_CHK, S_CLR, S_FIRE, S_WAIT, S_DONE, S_ERR} state_t;
    state_t        r_state;
    logic          r_rr_ptr, r_win, r_clr, r_owner, r_owner_vld;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_gnt, r_done, r_err;
    logic [31:0]   r_result;
    logic          r_calc_rst, r_calc_button;
    logic [7:0]    r_num1, r_num2;
    logic [2:0]    r_func;
    logic          w_win, w_illegal, w_need_clr;
    // r_rr_ptr names the requester that wins a tie; it flips away from every winner
    assign w_win      = (req0 && req1) ? r_rr_ptr : req1;
    assign w_illegal  = ((r_func == 3'd3 || r_func == 3'd4) && r_num2 == 8'd0) || r_func >= 3'd6;
    assign w_need_clr = !r_owner_vld || r_owner != r_win || r_clr;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= 1'b0;
            r_win         <= 1'b0;
            r_clr         <= 1'b0;
            r_owner       <= 1'b0;
            r_owner_vld   <= 1'b0;
            r_cnt         <= '0;
            r_gnt         <= 2'b00;
            r_done        <= 2'b00;
            r_err         <= 2'b00;
            r_result      <= 32'd0;
            r_calc_rst    <= 1'b0;
            r_calc_button <= 1'b0;
            r_num1        <= 8'd0;
            r_num2        <= 8'd0;
            r_func        <= 3'd0;
        end else begin
            r_done        <= 2'b00;
            r_err         <= 2'b00;
            r_calc_rst    <= 1'b0;
            r_calc_button <= 1'b0;
            case (r_state)
                S_IDLE: if (req0 || req1) begin
                    r_win    <= w_win;
                    r_rr_ptr <= ~w_win;
                    r_num1   <= w_win ? num1_1 : num1_0;
                    r_num2   <= w_win ? num2_1 : num2_0;
                    r_func   <= w_win ? func_1 : func_0;
                    r_clr    <= w_win ? clr1 : clr0;
                    r_gnt    <= w_win ? 2'b10 : 2'b01;
                    r_state  <= S_CHK;
                end
                S_CHK: begin
                    if (w_illegal) begin
                        r_err   <= r_gnt;
                        r_state <= S_ERR;
                    end else if (w_need_clr) begin
                        r_calc_rst <= 1'b1;
                        r_state    <= S_CLR;
                    end else begin
                        r_calc_button <= 1'b1;
                        r_state       <= S_FIRE;
                    end
                end
                S_CLR: begin
                    r_owner       <= r_win;
                    r_owner_vld   <= 1'b1;
                    r_calc_button <= 1'b1;
                    r_state       <= S_FIRE;
                end
                S_FIRE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == CW'(SETTLE_CYC - 1)) begin
                        r_result <= cal_result;
                        r_done   <= r_gnt;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    r_gnt   <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign gnt         = r_gnt;
    assign done        = r_done;
    assign err         = r_err;
    assign result      = r_result;
    assign calc_rst    = r_calc_rst;
    assign calc_button = r_calc_button;
    assign calc_num1   = r_num1;
    assign calc_num2   = r_num2;
    assign calc_func   = r_func;
endmodule

// File: tb/tb_calc_share_arbiter.sv
// tb_calc_share_arbiter: drives both requesters against a behavioural calculator model
// and scores results, grants and pulse timing.
module tb_calc_share_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;
    logic [7:0]  num1_0 = '0, num1_1 = '0, num2_0 = '0, num2_1 = '0;
    logic [2:0]  func_0 = '0, func_1 = '0;
    logic [1:0]  gnt, done, err;
    logic [31:0] result, cal_result;
    logic        calc_rst, calc_button;
    logic [7:0]  calc_num1, calc_num2;
    logic [2:0]  calc_func;
    logic [31:0] m_acc = '0;
    logic        m_first = 1'b1;
    logic [31:0] exp_q[$];
    logic [31:0] exp_r;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    calc_share_arbiter #(.SETTLE_CYC(2)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .clr0(clr0), .clr1(clr1),
        .num1_0(num1_0), .num1_1(num1_1), .num2_0(num2_0), .num2_1(num2_1),
        .func_0(func_0), .func_1(func_1), .gnt(gnt), .done(done), .err(err),
        .result(result), .calc_rst(calc_rst), .calc_button(calc_button),
        .calc_num1(calc_num1), .calc_num2(calc_num2), .calc_func(calc_func),
        .cal_result(cal_result)
    );

    // Chained calculator: first press after its reset uses num1, later presses the accumulator
    function automatic logic [31:0] calc_op(input logic [31:0] a, input logic [7:0] b, input logic [2:0] f);
        case (f)
            3'd0: calc_op = a + 32'(b);
            3'd1: calc_op = a - 32'(b);
            3'd2: calc_op = a * 32'(b);
            3'd3: calc_op = (b == 0) ? 32'd0 : a / 32'(b);
            3'd4: calc_op = (b == 0) ? 32'd0 : a % 32'(b);
            3'd5: calc_op = a & 32'(b);
            default: calc_op = 32'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (calc_rst) begin
            m_acc   <= 32'd0;
            m_first <= 1'b1;
        end else if (calc_button) begin
            m_acc   <= calc_op(m_first ? 32'(calc_num1) : m_acc, calc_num2, calc_func);
            m_first <= 1'b0;
        end
    end
    assign cal_result = m_acc;

    task automatic drive(input bit s, input logic [7:0] a, input logic [7:0] b, input logic [2:0] f, input bit c);
        if (s) begin
            req1 = 1'b1; num1_1 = a; num2_1 = b; func_1 = f; clr1 = c;
        end else begin
            req0 = 1'b1; num1_0 = a; num2_0 = b; func_0 = f; clr0 = c;
        end
    endtask

    // Records the cycle (relative to the drive cycle) of each pulse; stops one cycle after done/err
    task automatic observe(input int max, input logic [1:0] drop, output int c_rst, output int c_btn,
                           output int c_done, output int c_err, output logic [1:0] g1,
                           output logic [1:0] dv, output logic [1:0] ev, output logic [1:0] g_end,
                           output int viol);
        c_rst = -1; c_btn = -1; c_done = -1; c_err = -1;
        g1 = 2'b00; dv = 2'b00; ev = 2'b00; g_end = 2'b11; viol = 0;
        for (int c = 1; c <= max; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                g1 = gnt;
                if (drop[0]) begin req0 = 1'b0; clr0 = 1'b0; end
                if (drop[1]) begin req1 = 1'b0; clr1 = 1'b0; end
            end
            if (calc_rst && calc_button) viol++;
            if ($countones(gnt) > 1 || $countones(done) > 1 || $countones(err) > 1) viol++;
            if (calc_rst && c_rst < 0) c_rst = c;
            if (calc_button && c_btn < 0) c_btn = c;
            if (|done && c_done < 0) begin c_done = c; dv = done; end
            if (|err && c_err < 0) begin c_err = c; ev = err; end
            if ((c_done > 0 && c == c_done + 1) || (c_err > 0 && c == c_err + 1)) begin
                g_end = gnt;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (gnt !== 2'b00 || done !== 2'b00 || err !== 2'b00) begin errors++; $display("FAIL reset_hs gnt=%b done=%b err=%b expected 00", gnt, done, err); end
        checks++; if (result !== 32'd0 || calc_rst !== 1'b0 || calc_button !== 1'b0) begin errors++; $display("FAIL reset_out result=%h rst=%b btn=%b expected 0", result, calc_rst, calc_button); end
        checks++; if ({calc_num1, calc_num2, calc_func} !== 19'd0) begin errors++; $display("FAIL reset_ops got %h expected 0", {calc_num1, calc_num2, calc_func}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_first();
        int cr, cb, cd, ce, v;
        logic [1:0] g1, dv, ev, ge;
        drive(0, 8'h12, 8'h34, 3'd0, 1'b0);
        exp_q.push_back(32'h46);
        observe(20, 2'b01, cr, cb, cd, ce, g1, dv, ev, ge, v);
        checks++; if (g1 !== 2'b01) begin errors++; $display("FAIL first_gnt got %b expected 01", g1); end
        checks++; if (cr !== 2 || cb !== 3) begin errors++; $display("FAIL first_pulses rst@%0d btn@%0d expected 2/3", cr, cb); end
        checks++; if (cd !== 6 || dv !== 2'b01) begin errors++; $display("FAIL first_done at %0d val %b expected 6/01", cd, dv); end
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (result !== exp_r) begin errors++; $display("FAIL first_result got %h expected %h", result, exp_r); end
        checks++; if (ge !== 2'b00 || v !== 0) begin errors++; $display("FAIL first_end gnt=%b viol=%0d expected 00/0", ge, v); end
    endtask

    task automatic test_chain();
        int cr, cb, cd, ce, v;
        logic [1:0] g1, dv, ev, ge;
        drive(0, 8'h99, 8'h03, 3'd2, 1'b0);
        exp_q.push_back(32'hD2);
        observe(20, 2'b01, cr, cb, cd, ce, g1, dv, ev, ge, v);
        checks++; if (cr !== -1 || cb !== 2) begin errors++; $display("FAIL chain_pulses rst@%0d btn@%0d expected none/2", cr, cb); end
        checks++; if (cd !== 5 || dv !== 2'b01) begin errors++; $display("FAIL chain_done at %0d val %b expected 5/01", cd, dv); end
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (result !== exp_r) begin errors++; $display("FAIL chain_result got %h expected %h", result, exp_r); end
    endtask

    task automatic test_both();
        int cr, cb, cd, ce, v;
        logic [1:0] g1, dv, ev, ge;
        drive(1, 8'h07, 8'h02, 3'd3, 1'b0);
        drive(0, 8'h20, 8'h05, 3'd1, 1'b0);
        exp_q.push_back(32'h3);
        exp_q.push_back(32'h1B);
        observe(20, 2'b10, cr, cb, cd, ce, g1, dv, ev, ge, v);
        checks++; if (g1 !== 2'b10 || cr !== 2 || cd !== 6 || dv !== 2'b10) begin errors++; $display("FAIL both_first gnt=%b rst@%0d done@%0d %b expected 10/2/6/10", g1, cr, cd, dv); end
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (result !== exp_r) begin errors++; $display("FAIL both_result1 got %h expected %h", result, exp_r); end
        observe(20, 2'b01, cr, cb, cd, ce, g1, dv, ev, ge, v);
        checks++; if (g1 !== 2'b01 || cr !== 2 || cd !== 6 || dv !== 2'b01) begin errors++; $display("FAIL both_second gnt=%b rst@%0d done@%0d %b expected 01/2/6/01", g1, cr, cd, dv); end
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (result !== exp_r || v !== 0) begin errors++; $display("FAIL both_result2 got %h viol=%0d expected %h/0", result, v, exp_r); end
    endtask

    task automatic test_err();
        int cr, cb, cd, ce, v;
        logic [1:0] g1, dv, ev, ge;
        drive(1, 8'h05, 8'h00, 3'd4, 1'b0);
        observe(20, 2'b10, cr, cb, cd, ce, g1, dv, ev, ge, v);
        checks++; if (ce !== 2 || ev !== 2'b10 || cd !== -1) begin errors++; $display("FAIL err_pulse at %0d val %b done@%0d expected 2/10/none", ce, ev, cd); end
        checks++; if (cr !== -1 || cb !== -1) begin errors++; $display("FAIL err_calc rst@%0d btn@%0d expected none", cr, cb); end
        checks++; if (result !== 32'h1B || ge !== 2'b00) begin errors++; $display("FAIL err_hold result=%h gnt=%b expected 1b/00", result, ge); end
    endtask

    task automatic test_reset_mid();
        int cr, cb, cd, ce, v;
        logic [1:0] g1, dv, ev, ge;
        logic seen;
        drive(0, 8'h01, 8'h01, 3'd0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) req0 = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (gnt !== 2'b00 || done !== 2'b00 || err !== 2'b00 || result !== 32'd0 || calc_num1 !== 8'd0) begin errors++; $display("FAIL midrst_out gnt=%b done=%b err=%b result=%h num1=%h expected 0", gnt, done, err, result, calc_num1); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            seen |= |done | |err;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_quiet got pulse=%b expected 0", seen); end
        drive(0, 8'h02, 8'h03, 3'd0, 1'b0);
        exp_q.push_back(32'h5);
        observe(20, 2'b01, cr, cb, cd, ce, g1, dv, ev, ge, v);
        checks++; if (cr !== 2 || cd !== 6) begin errors++; $display("FAIL midrst_clr rst@%0d done@%0d expected 2/6", cr, cd); end
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (result !== exp_r) begin errors++; $display("FAIL midrst_result got %h expected %h", result, exp_r); end
    endtask

    task automatic test_err_rr();
        int cr, cb, cd, ce, v;
        logic [1:0] g1, dv, ev, ge;
        drive(1, 8'h01, 8'h01, 3'd7, 1'b0);
        drive(0, 8'h00, 8'h04, 3'd0, 1'b0);
        observe(20, 2'b10, cr, cb, cd, ce, g1, dv, ev, ge, v);
        checks++; if (g1 !== 2'b10 || ce !== 2 || ev !== 2'b10) begin errors++; $display("FAIL errrr_first gnt=%b err@%0d %b expected 10/2/10", g1, ce, ev); end
        exp_q.push_back(32'h9);
        observe(20, 2'b01, cr, cb, cd, ce, g1, dv, ev, ge, v);
        checks++; if (g1 !== 2'b01 || cr !== -1 || cd !== 5) begin errors++; $display("FAIL errrr_next gnt=%b rst@%0d done@%0d expected 01/none/5", g1, cr, cd); end
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (result !== exp_r) begin errors++; $display("FAIL errrr_result got %h expected %h", result, exp_r); end
    endtask

    task automatic test_forced_clr();
        int cr, cb, cd, ce, v;
        logic [1:0] g1, dv, ev, ge;
        drive(1, 8'h09, 8'h04, 3'd1, 1'b0);
        exp_q.push_back(32'h5);
        observe(20, 2'b10, cr, cb, cd, ce, g1, dv, ev, ge, v);
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (result !== exp_r || dv !== 2'b10) begin errors++; $display("FAIL clr_setup result=%h done=%b expected %h/10", result, dv, exp_r); end
        drive(1, 8'h30, 8'h10, 3'd1, 1'b1);
        exp_q.push_back(32'h20);
        observe(20, 2'b10, cr, cb, cd, ce, g1, dv, ev, ge, v);
        checks++; if (cr !== 2 || cd !== 6) begin errors++; $display("FAIL clr_forced rst@%0d done@%0d expected 2/6", cr, cd); end
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (result !== exp_r || v !== 0) begin errors++; $display("FAIL clr_result got %h viol=%0d expected %h/0", result, v, exp_r); end
    endtask

    initial begin
        test_reset();
        test_first();
        test_chain();
        test_both();
        test_err();
        test_reset_mid();
        test_err_rr();
        test_forced_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
